key_expansion_2om: RTL and testbench

KEY_EXPANSION_2OM -- requirements
Module: key_expansion_2om

---
 rtl/key_expansion_2om_pkg.sv | 24 ++
 rtl/key_expansion_2om_word_update.sv | 18 +
 rtl/key_expansion_2om.sv | 139 +++++++++++++
 tb/tb_key_expansion_2om.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_expansion_2om_pkg.sv
// rtl/key_expansion_2om_pkg.sv - shared FSM states, constants and word helpers for the masked key expansion
package key_exp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT,
    UPDATE,
    HOLD
  } state_t;

  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] RCON_POLY = 8'h1B;
  localparam logic [3:0] ROUNDS    = 4'd10;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? RCON_POLY : 8'h00);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/key_expansion_2om_word_update.sv
// rtl/key_expansion_2om_word_update.sv - four-word XOR chain of one key share
module key_word_update
  import key_exp_pkg::*;
(
  input  logic [127:0] w,
  input  logic [31:0]  t,
  output logic [127:0] w_next
);

  logic [31:0] w0n, w1n, w2n, w3n;

  assign w0n    = w[127:96] ^ t;
  assign w1n    = w[95:64]  ^ w0n;
  assign w2n    = w[63:32]  ^ w1n;
  assign w3n    = w[31:0]   ^ w2n;
  assign w_next = {w0n, w1n, w2n, w3n};

endmodule

// File: rtl/key_expansion_2om.sv
// rtl/key_expansion_2om.sv - three-share AES-128 key expansion around an external masked S-box unit
// Optional KEYEXP_SHARE_REFRESH_EN adds refresh_r, re-randomising shares 1 and 2 on every update.
module key_expansion_2om
  import key_exp_pkg::*;
#(
  parameter int SBOX_LAT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key1,
  input  logic [127:0] key2,
  input  logic [127:0] key3,
`ifdef KEYEXP_SHARE_REFRESH_EN
  input  logic [127:0] refresh_r,
`endif
  input  logic         next,
  output logic [31:0]  sbox_in1,
  output logic [31:0]  sbox_in2,
  output logic [31:0]  sbox_in3,
  input  logic [31:0]  sbox_out1,
  input  logic [31:0]  sbox_out2,
  input  logic [31:0]  sbox_out3,
  output logic         guards_mux_sel,
  output logic         guards_reg_en,
  output logic [127:0] rk1,
  output logic [127:0] rk2,
  output logic [127:0] rk3,
  output logic         rk_valid,
  output logic [3:0]   round,
  output logic         busy
);

  localparam int CW = (SBOX_LAT > 1) ? $clog2(SBOX_LAT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(SBOX_LAT - 1);

  state_t        state, state_next;
  logic [7:0]    rcon;
  logic [CW-1:0] wait_cnt;
  logic [31:0]   t1, t2, t3;
  logic [127:0]  u1, u2, u3, r1, r2;

  // rcon is public, so injecting it into share 1 alone keeps the shares independent
  assign t1 = {sbox_out1[31:24] ^ rcon, sbox_out1[23:0]};
  assign t2 = sbox_out2;
  assign t3 = sbox_out3;

  key_word_update u_share1 (.w(rk1), .t(t1), .w_next(u1));
  key_word_update u_share2 (.w(rk2), .t(t2), .w_next(u2));
  key_word_update u_share3 (.w(rk3), .t(t3), .w_next(u3));

`ifdef KEYEXP_SHARE_REFRESH_EN
  assign r1 = u1 ^ refresh_r;
  assign r2 = u2 ^ refresh_r;
`else
  assign r1 = u1;
  assign r2 = u2;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next     = state;
    busy           = 1'b1;
    rk_valid       = 1'b0;
    guards_mux_sel = 1'b0;
    guards_reg_en  = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = HOLD;
      end
      HOLD: begin
        rk_valid = 1'b1;
        if (next) state_next = (round == ROUNDS) ? IDLE : SEND;
      end
      SEND: begin
        guards_mux_sel = (round == 4'd0);
        state_next     = (SBOX_LAT == 1) ? UPDATE : WAIT;
      end
      WAIT: begin
        if (wait_cnt == WAIT_LAST) state_next = UPDATE;
      end
      UPDATE: begin
        guards_reg_en = 1'b1;
        state_next    = HOLD;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rk1      <= '0;
      rk2      <= '0;
      rk3      <= '0;
      sbox_in1 <= '0;
      sbox_in2 <= '0;
      sbox_in3 <= '0;
      round    <= '0;
      rcon     <= RCON_INIT;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            rk1   <= key1;
            rk2   <= key2;
            rk3   <= key3;
            round <= '0;
            rcon  <= RCON_INIT;
          end
        end
        HOLD: begin
          // loaded on the way into SEND and held until the next request
          if (next && round != ROUNDS) begin
            sbox_in1 <= rot_word(rk1[31:0]);
            sbox_in2 <= rot_word(rk2[31:0]);
            sbox_in3 <= rot_word(rk3[31:0]);
          end
        end
        SEND:    wait_cnt <= CW'(1);
        WAIT:    wait_cnt <= wait_cnt + CW'(1);
        UPDATE: begin
          rk1   <= r1;
          rk2   <= r2;
          rk3   <= u3;
          round <= round + 4'd1;
          rcon  <= xtime(rcon);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_key_expansion_2om.sv
// tb/tb_key_expansion_2om.sv - checks key_expansion_2om against a plain AES-128 key schedule and a latency-exact S-box stub
module tb_key_expansion_2om;

  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         rst, start, next;
  logic [127:0] key1, key2, key3, refresh_r;
  logic [31:0]  sbox_in1, sbox_in2, sbox_in3;
  logic [31:0]  sbox_out1, sbox_out2, sbox_out3;
  logic         guards_mux_sel, guards_reg_en, rk_valid, busy;
  logic [127:0] rk1, rk2, rk3;
  logic [3:0]   round;

  int vectors = 0;
  int errors  = 0;

  logic [7:0]   sbox_tab [256];
  logic [7:0]   rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
  logic [127:0] exp_rk [11];

  logic         pend   = 1'b0;
  int           cnt    = 0;
  logic         prev_v = 1'b0;
  logic [31:0]  send_x;
  int           n_mux  = 0;
  int           n_en   = 0;

  key_expansion_2om #(.SBOX_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start(start),
    .key1(key1), .key2(key2), .key3(key3),
`ifdef KEYEXP_SHARE_REFRESH_EN
    .refresh_r(refresh_r),
`endif
    .next(next),
    .sbox_in1(sbox_in1), .sbox_in2(sbox_in2), .sbox_in3(sbox_in3),
    .sbox_out1(sbox_out1), .sbox_out2(sbox_out2), .sbox_out3(sbox_out3),
    .guards_mux_sel(guards_mux_sel), .guards_reg_en(guards_reg_en),
    .rk1(rk1), .rk2(rk2), .rk3(rk3),
    .rk_valid(rk_valid), .round(round), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // S-box from first principles: GF(2^8) inverse (x^254) followed by the affine map
  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] v;
    v = 8'h01;
    for (int i = 0; i < 254; i++) v = gmul(v, x);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
  endfunction

  task automatic build_model(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rcon_tab[i/4-1], 24'h0};
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // S-box stub answers exactly LAT cycles after SEND; every other cycle it returns noise
  always @(negedge clk) begin
    logic        send_now, fire;
    logic [31:0] y, m1, m2;
    refresh_r = {$urandom, $urandom, $urandom, $urandom};
    sbox_out1 = $urandom;
    sbox_out2 = $urandom;
    sbox_out3 = $urandom;
    if (rst) begin
      pend   = 1'b0;
      prev_v = 1'b0;
    end else begin
      send_now = busy && !rk_valid && prev_v;
      fire     = pend && (cnt == 1);
      chk("guards_mux_sel", guards_mux_sel, send_now && (round == 4'd0));
      chk("guards_reg_en", guards_reg_en, fire);
      if (rk_valid) begin
        chk("rk_valid_busy", busy, 1);
        if (round > 4'd10) chk("round_range", round, 10);
        else chk($sformatf("rk_round%0d", round), rk1 ^ rk2 ^ rk3, exp_rk[round]);
      end
      if (guards_mux_sel) n_mux++;
      if (guards_reg_en) n_en++;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          pend = 1'b0;
          y  = sub_word(send_x);
          m1 = $urandom;
          m2 = $urandom;
          sbox_out1 = y ^ m1 ^ m2;
          sbox_out2 = m1;
          sbox_out3 = m2;
        end
      end
      if (send_now) begin
        send_x = sbox_in1 ^ sbox_in2 ^ sbox_in3;
        pend   = 1'b1;
        cnt    = LAT;
      end
      prev_v = rk_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name, output int cyc);
    cyc = 0;
    while (!rk_valid && cyc < 100) begin
      tick();
      cyc++;
    end
    if (!rk_valid) begin
      vectors++;
      errors++;
      $display("FAIL %s: rk_valid got %b after %0d cycles, required 1", name, rk_valid, cyc);
    end
  endtask

  task automatic advance();
    int c;
    next = 1'b1;
    tick();
    next = 1'b0;
    wait_valid("advance", c);
  endtask

  task automatic start_exp(input logic [127:0] k);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_valid_round", {rk_valid, round}, {1'b1, 4'd0});
    chk("start_key", rk1 ^ rk2 ^ rk3, k);
  endtask

  task automatic finish_exp(input string name);
    next = 1'b1;
    tick();
    next = 1'b0;
    chk(name, {busy, rk_valid}, 2'b00);
  endtask

  task automatic check_reset(input string name);
    chk({name, "_ctl"}, {busy, rk_valid, guards_mux_sel, guards_reg_en, round}, 0);
    chk({name, "_rk"}, rk1 | rk2 | rk3, 0);
    chk({name, "_sbox_in"}, {sbox_in1, sbox_in2, sbox_in3}, 0);
  endtask

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  initial begin
    logic [127:0] s1, s2, s3, kc, sv1, sv2, ref_k;
    logic [3:0]   sr;
    int           c, maxr;

    for (int i = 0; i < 256; i++) sbox_tab[i] = sbox_calc(8'(i));

    rst   = 1'b1;
    start = 1'b1;
    next  = 1'b1;
    key1  = {$urandom, $urandom, $urandom, $urandom};
    key2  = 128'h0;
    key3  = 128'h0;
    tick();
    tick();
    check_reset("rst_hold");
    rst   = 1'b0;
    start = 1'b0;
    next  = 1'b0;
    tick();
    check_reset("after_rst");

    // single live share
    key1 = FIPS_KEY;
    key2 = 128'h0;
    key3 = 128'h0;
    build_model(FIPS_KEY);
    chk("model_r1_literal", exp_rk[1], FIPS_R1);
    chk("model_r10_literal", exp_rk[10], FIPS_R10);
    n_mux = 0;
    n_en  = 0;
    start_exp(FIPS_KEY);
    advance();
    chk("r1_literal", rk1 ^ rk2 ^ rk3, FIPS_R1);
    while (rk_valid && round < 4'd10) advance();
    chk("a_last_round", round, 10);
    chk("a_mux_count", n_mux, 1);
    chk("a_en_count", n_en, 10);
    finish_exp("a_idle_after_r10");

    // random re-split, long hold, latency and ignored start
    key2 = {$urandom, $urandom, $urandom, $urandom};
    key3 = {$urandom, $urandom, $urandom, $urandom};
    key1 = FIPS_KEY ^ key2 ^ key3;
    n_mux = 0;
    n_en  = 0;
    start_exp(FIPS_KEY);
    while (rk_valid && round < 4'd3) advance();
    s1 = rk1;
    s2 = rk2;
    s3 = rk3;
    sr = round;
    chk("hold_round", sr, 3);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("hold_stable", (rk1 == s1) && (rk2 == s2) && (rk3 == s3) && (round == sr) && rk_valid, 1);
    end
    next = 1'b1;
    tick();
    next = 1'b0;
    wait_valid("r4_latency", c);
    chk("r4_latency", c, LAT + 1);
    chk("r4_round", round, 4);
    sv1 = key1;
    sv2 = key2;
    next = 1'b1;
    tick();
    next  = 1'b0;
    start = 1'b1;
    key1  = ~key1;
    key2  = {$urandom, $urandom, $urandom, $urandom};
    tick();
    start = 1'b0;
    key1  = sv1;
    key2  = sv2;
    wait_valid("r5_after_busy_start", c);
    chk("r5_round", round, 5);
    while (rk_valid && round < 4'd10) advance();
    ref_k = rk1 ^ rk2 ^ rk3;
    chk("r10_literal", ref_k, FIPS_R10);
    chk("share1_differs", rk1 != ref_k, 1);
    chk("share2_differs", rk2 != ref_k, 1);
    chk("share3_differs", rk3 != ref_k, 1);
    chk("b_mux_count", n_mux, 1);
    chk("b_en_count", n_en, 10);
    finish_exp("b_idle_after_r10");

    // start beats next in IDLE, then reset in WAIT of round 5
    kc   = {$urandom, $urandom, $urandom, $urandom};
    key2 = {$urandom, $urandom, $urandom, $urandom};
    key3 = {$urandom, $urandom, $urandom, $urandom};
    key1 = kc ^ key2 ^ key3;
    build_model(kc);
    start = 1'b1;
    next  = 1'b1;
    tick();
    start = 1'b0;
    next  = 1'b0;
    chk("start_wins", {busy, rk_valid, round}, {1'b1, 1'b1, 4'd0});
    chk("start_wins_key", rk1 ^ rk2 ^ rk3, kc);
    while (rk_valid && round < 4'd4) advance();
    next = 1'b1;
    tick();
    next = 1'b0;
    tick();
    chk("in_wait", {busy, rk_valid}, 2'b10);
    rst = 1'b1;
    tick();
    check_reset("mid_rst");
    rst = 1'b0;
    tick();
    check_reset("mid_rst_after");

    // restart with next held high throughout
    n_mux = 0;
    n_en  = 0;
    maxr  = 0;
    start = 1'b1;
    next  = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_round0", {rk_valid, round}, {1'b1, 4'd0});
    c = 0;
    while (busy && c < 300) begin
      if (rk_valid && int'(round) > maxr) maxr = int'(round);
      tick();
      c++;
    end
    next = 1'b0;
    chk("tied_next_done", busy, 0);
    chk("tied_next_last_round", maxr, 10);
    chk("c_mux_count", n_mux, 1);
    chk("c_en_count", n_en, 10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
